mc_maindec_fsm: RTL and testbench

//   Multicycle main controller: successor to the single-cycle opcode decoder.

---
 rtl/mc_maindec_fsm.sv | 196 +++++++++++++++++++
 tb/tb_mc_maindec_fsm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec_fsm.sv
// mc_maindec_fsm: multicycle main controller.
// Runs each instruction through FETCH/DECODE/EXEC/MEM/WB. It waits on the memory
// ready handshake, with a bus-error timeout, and takes prioritised interrupts
// through a one-cycle IACK state.
// Optional feature: define ILLEGAL_TRAP_EN to make unknown opcodes trap through the
// IACK state with irq_id all ones. Without it, unknown opcodes behave as NOPs.
module mc_maindec_fsm #(
  parameter int          IRQ_LINES = 4,
  parameter int          WAIT_MAX  = 15,
  parameter logic [5:0]  IACK_OP   = 6'h30,
  localparam int         IDW       = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [5:0]           opcode_i,
  input  logic [IRQ_LINES-1:0] irq_i,
  input  logic                 mem_ready_i,
  output logic                 mem_req_o,
  output logic                 pc_we_o,
  output logic                 ir_we_o,
  output logic                 branch_o,
  output logic                 jump_o,
  output logic                 jal_o,
  output logic                 reg_dst_o,
  output logic                 we_reg_o,
  output logic                 alu_src_o,
  output logic                 we_dm_o,
  output logic                 dm2reg_o,
  output logic [1:0]           alu_op_o,
  output logic                 iack_o,
  output logic [IDW-1:0]       irq_id_o,
  output logic                 bus_err_o
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_IACK
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     op_q, op_d;
  logic [IDW-1:0] irqId_q, irqId_d;
  logic [7:0]     waitCnt_q, waitCnt_d;

  logic [IDW-1:0] irqLow;
  logic           legalOp;
  logic           timeout;

  logic           memReq, pcWe, irWe, branch, jump, jal, regDst, weReg;
  logic           aluSrc, weDm, dm2reg, iack, busErr;
  logic [1:0]     aluOp;

  // Find the lowest-numbered pending interrupt, which is the highest priority one.
  always_comb begin
    irqLow = '0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (irq_i[i]) irqLow = IDW'(i);
    end
  end

  // Classify the incoming opcode and detect a memory wait that has run too long.
  always_comb begin
    legalOp = (opcode_i == OP_R)   || (opcode_i == OP_ADDI) || (opcode_i == OP_BEQ) ||
              (opcode_i == OP_LW)  || (opcode_i == OP_SW)   || (opcode_i == OP_J)   ||
              (opcode_i == OP_JAL) || (opcode_i == IACK_OP);
    timeout = ((state_q == S_FETCH) || (state_q == S_MEM)) && (waitCnt_q == WAIT_LIMIT);
  end

  // Next-state and control-strobe decode. The wait counter is 0 unless a memory access is stalling.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    irqId_d   = irqId_q;
    waitCnt_d = '0;
    memReq = 1'b0; pcWe   = 1'b0; irWe   = 1'b0; branch = 1'b0;
    jump   = 1'b0; jal    = 1'b0; regDst = 1'b0; weReg  = 1'b0;
    aluSrc = 1'b0; weDm   = 1'b0; dm2reg = 1'b0; iack   = 1'b0;
    busErr = 1'b0; aluOp  = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        if ((waitCnt_q == '0) && (|irq_i)) begin
          state_d = S_IACK;
          irqId_d = irqLow;
        end else begin
          memReq = 1'b1;
          if (timeout) begin
            busErr = 1'b1;
          end else if (mem_ready_i) begin
            irWe    = 1'b1;
            pcWe    = 1'b1;
            state_d = S_DECODE;
          end else begin
            waitCnt_d = waitCnt_q + 8'd1;
          end
        end
      end
      S_DECODE: begin
        op_d = opcode_i;
        if (legalOp) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_IACK;
          irqId_d = '1;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_R:    begin aluOp = 2'b10; state_d = S_WB; end
          OP_ADDI: begin aluSrc = 1'b1; state_d = S_WB; end
          OP_BEQ:  begin branch = 1'b1; aluOp = 2'b01; end
          OP_J:    begin jump = 1'b1; pcWe = 1'b1; end
          OP_JAL:  begin jump = 1'b1; jal = 1'b1; weReg = 1'b1; pcWe = 1'b1; end
          OP_LW,
          OP_SW:   begin aluSrc = 1'b1; state_d = S_MEM; end
          IACK_OP: begin state_d = S_IACK; irqId_d = '0; end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        memReq = 1'b1;
        if (timeout) begin
          busErr  = 1'b1;
          state_d = S_FETCH;
        end else begin
          weDm = (op_q == OP_SW);
          if (mem_ready_i) begin
            state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
          end else begin
            waitCnt_d = waitCnt_q + 8'd1;
          end
        end
      end
      S_WB: begin
        weReg   = 1'b1;
        regDst  = (op_q == OP_R);
        dm2reg  = (op_q == OP_LW);
        aluSrc  = (op_q == OP_ADDI);
        state_d = S_FETCH;
      end
      S_IACK: begin
        iack    = 1'b1;
        pcWe    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, latched opcode, acknowledged irq index and wait counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      irqId_q   <= '0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      irqId_q   <= irqId_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // While reset is asserted, every output is held low so an in-flight access is dropped cleanly.
  always_comb begin
    mem_req_o = memReq & ~rst_i;
    pc_we_o   = pcWe   & ~rst_i;
    ir_we_o   = irWe   & ~rst_i;
    branch_o  = branch & ~rst_i;
    jump_o    = jump   & ~rst_i;
    jal_o     = jal    & ~rst_i;
    reg_dst_o = regDst & ~rst_i;
    we_reg_o  = weReg  & ~rst_i;
    alu_src_o = aluSrc & ~rst_i;
    we_dm_o   = weDm   & ~rst_i;
    dm2reg_o  = dm2reg & ~rst_i;
    iack_o    = iack   & ~rst_i;
    bus_err_o = busErr & ~rst_i;
    alu_op_o  = rst_i ? 2'b00 : aluOp;
    irq_id_o  = rst_i ? '0 : irqId_q;
  end

endmodule

// File: tb/tb_mc_maindec_fsm.sv
// tb_mc_maindec_fsm: self-checking bench for mc_maindec_fsm.
// An instruction-level model expands each instruction into its expected per-cycle
// control vector. It also expands the mem_ready, irq and opcode values to drive in
// each cycle. Each test replays these queues against the DUT.
module tb_mc_maindec_fsm;

  localparam int WAIT_MAX = 15;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_IACK = 6'h30;

  localparam logic [14:0] M_REQ  = 15'h4000, M_PCWE = 15'h2000, M_IRWE = 15'h1000;
  localparam logic [14:0] M_BR   = 15'h0800, M_J    = 15'h0400, M_JAL  = 15'h0200;
  localparam logic [14:0] M_RD   = 15'h0100, M_WREG = 15'h0080, M_ASRC = 15'h0040;
  localparam logic [14:0] M_WDM  = 15'h0020, M_D2R  = 15'h0010, A_F    = 15'h0008;
  localparam logic [14:0] A_SUB  = 15'h0004, M_IACK = 15'h0002, M_BERR = 15'h0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [3:0] irq;
  logic       memReady;
  logic       memReq, pcWe, irWe, branch, jump, jal, regDst, weReg;
  logic       aluSrc, weDm, dm2reg, iack, busErr;
  logic [1:0] aluOp;
  logic [1:0] irqId;
  logic [14:0] obs;

  int total = 0;
  int bad   = 0;

  logic [14:0] expQ[$];
  logic [1:0]  idQ[$];
  bit          rdyQ[$];
  logic [3:0]  irqQ[$];
  logic [5:0]  opQ[$];
  logic [1:0]  expId = 2'd0;
  logic [14:0] curExp;
  logic [1:0]  curId;
  int          cyc;

  always #5 clk = ~clk;

  mc_maindec_fsm dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .irq_i(irq), .mem_ready_i(memReady),
    .mem_req_o(memReq), .pc_we_o(pcWe), .ir_we_o(irWe), .branch_o(branch),
    .jump_o(jump), .jal_o(jal), .reg_dst_o(regDst), .we_reg_o(weReg),
    .alu_src_o(aluSrc), .we_dm_o(weDm), .dm2reg_o(dm2reg), .alu_op_o(aluOp),
    .iack_o(iack), .irq_id_o(irqId), .bus_err_o(busErr)
  );

  assign obs = {memReq, pcWe, irWe, branch, jump, jal, regDst, weReg,
                aluSrc, weDm, dm2reg, aluOp, iack, busErr};

  // Append one expected cycle plus the inputs to drive during it.
  task automatic push(input logic [14:0] v, input bit rdy, input logic [3:0] irqv,
                      input logic [5:0] opv);
    expQ.push_back(v);
    idQ.push_back(expId);
    rdyQ.push_back(rdy);
    irqQ.push_back(irqv);
    opQ.push_back(opv);
  endtask

  function automatic logic [1:0] lowestSet(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Expand a memory access phase: stall cycles, then either completion or timeout.
  task automatic model_access(input logic [14:0] v, input int waits, output bit timedOut);
    timedOut = (waits >= WAIT_MAX);
    if (timedOut) begin
      for (int i = 0; i < WAIT_MAX; i++) push(v, 1'b0, 4'd0, 6'($urandom));
      push(M_REQ | M_BERR, 1'b0, 4'd0, 6'($urandom));
    end else begin
      for (int i = 0; i < waits; i++) push(v, 1'b0, 4'd0, 6'($urandom));
      push(v, 1'b1, 4'd0, 6'($urandom));
    end
  endtask

  // Instruction-level reference: fetch, decode, then the class-specific phases.
  task automatic model_instr(input logic [5:0] op, input int fw, input int mw);
    bit to;
    model_access(M_REQ, fw, to);
    expQ[expQ.size()-1] = M_REQ | M_IRWE | M_PCWE;
    push(15'd0, 1'($urandom), 4'd0, op);
    case (op)
      OP_R:    begin push(A_F, 1'($urandom), 4'd0, 6'($urandom));
                     push(M_WREG | M_RD, 1'($urandom), 4'd0, 6'($urandom)); end
      OP_ADDI: begin push(M_ASRC, 1'($urandom), 4'd0, 6'($urandom));
                     push(M_WREG | M_ASRC, 1'($urandom), 4'd0, 6'($urandom)); end
      OP_BEQ:  push(M_BR | A_SUB, 1'($urandom), 4'd0, 6'($urandom));
      OP_J:    push(M_J | M_PCWE, 1'($urandom), 4'd0, 6'($urandom));
      OP_JAL:  push(M_J | M_JAL | M_WREG | M_PCWE, 1'($urandom), 4'd0, 6'($urandom));
      OP_LW:   begin push(M_ASRC, 1'($urandom), 4'd0, 6'($urandom));
                     model_access(M_REQ, mw, to);
                     if (!to) push(M_WREG | M_D2R, 1'($urandom), 4'd0, 6'($urandom)); end
      OP_SW:   begin push(M_ASRC, 1'($urandom), 4'd0, 6'($urandom));
                     model_access(M_REQ | M_WDM, mw, to); end
      OP_IACK: begin push(15'd0, 1'($urandom), 4'd0, 6'($urandom));
                     expId = 2'd0;
                     push(M_IACK | M_PCWE, 1'($urandom), 4'd0, 6'($urandom)); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        expId = 2'b11;
        push(M_IACK | M_PCWE, 1'($urandom), 4'd0, 6'($urandom));
`endif
      end
    endcase
  endtask

  // Hardware interrupt seen at the start of FETCH: idle cycle, then the IACK cycle.
  task automatic model_irq(input logic [3:0] irqv);
    push(15'd0, 1'($urandom), irqv, 6'($urandom));
    expId = lowestSet(irqv);
    push(M_IACK | M_PCWE, 1'($urandom), 4'($urandom), 6'($urandom));
  endtask

  // Drive the next queued cycle and move to the sampling point.
  task automatic apply_next();
    memReady = rdyQ.pop_front();
    irq      = irqQ.pop_front();
    opcode   = opQ.pop_front();
    curExp   = expQ.pop_front();
    curId    = idQ.pop_front();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (obs !== 15'd0 || irqId !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got vec=%h id=%0d want vec=0000 id=0", obs, irqId);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    model_instr(OP_R, 0, 0);
    cyc = 0;
    while (expQ.size() != 0) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL rtype c%0d: got vec=%h id=%0d want vec=%h id=%0d", cyc, obs, irqId, curExp, curId);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    model_instr(OP_LW, 0, 3);
    cyc = 0;
    while (expQ.size() != 0) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL lw_wait c%0d: got vec=%h id=%0d want vec=%h id=%0d", cyc, obs, irqId, curExp, curId);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_irq();
    model_irq(4'b1010);
    model_instr(OP_BEQ, 1, 0);
    model_instr(OP_IACK, 0, 0);
    model_irq(4'b1000);
    model_instr(OP_J, 0, 0);
    cyc = 0;
    while (expQ.size() != 0) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL irq c%0d: got vec=%h id=%0d want vec=%h id=%0d", cyc, obs, irqId, curExp, curId);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_timeout();
    model_instr(OP_SW, 0, WAIT_MAX);
    model_instr(OP_LW, 2, WAIT_MAX + 3);
    model_instr(OP_ADDI, 14, 0);
    cyc = 0;
    while (expQ.size() != 0) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL timeout c%0d: got vec=%h id=%0d want vec=%h id=%0d", cyc, obs, irqId, curExp, curId);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    model_instr(6'h3F, 0, 0);
    model_instr(OP_BEQ, 0, 0);
    model_instr(6'h11, 1, 0);
    model_instr(OP_SW, 0, 1);
    cyc = 0;
    while (expQ.size() != 0) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL illegal c%0d: got vec=%h id=%0d want vec=%h id=%0d", cyc, obs, irqId, curExp, curId);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    model_instr(OP_SW, 0, 6);
    for (int i = 0; i < 5; i++) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL reset_mid_pre c%0d: got vec=%h want vec=%h", i, obs, curExp);
      end
      @(posedge clk); #1;
    end
    expQ.delete(); idQ.delete(); rdyQ.delete(); irqQ.delete(); opQ.delete();
    rst = 1'b1; memReady = 1'b1; irq = 4'd0;
    @(negedge clk);
    total++;
    if (obs !== 15'd0 || irqId !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_hold: got vec=%h id=%0d want vec=0000 id=0", obs, irqId);
    end
    @(posedge clk); #1;
    rst = 1'b0; memReady = 1'b0; expId = 2'd0;
    @(negedge clk);
    total++;
    if (obs !== M_REQ || irqId !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_fetch: got vec=%h id=%0d want vec=%h id=0", obs, irqId, M_REQ);
    end
    @(posedge clk); #1;
    model_instr(OP_ADDI, 0, 0);
    cyc = 0;
    while (expQ.size() != 0) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL reset_mid_post c%0d: got vec=%h id=%0d want vec=%h id=%0d", cyc, obs, irqId, curExp, curId);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [10];
    ops = '{OP_R, OP_ADDI, OP_BEQ, OP_LW, OP_SW, OP_J, OP_JAL, OP_IACK, 6'h3F, 6'h01};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) model_irq(4'($urandom_range(1, 15)));
      model_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 4));
    end
    cyc = 0;
    while (expQ.size() != 0) begin
      apply_next();
      total++;
      if (obs !== curExp || irqId !== curId) begin
        bad++;
        $display("[TB] FAIL random c%0d: got vec=%h id=%0d want vec=%h id=%0d", cyc, obs, irqId, curExp, curId);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1; opcode = 6'd0; irq = 4'd0; memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_irq();
    test_sw_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
